// File: rtl/hd_class_similarity_argmax.sv
// Hamming-distance nearest-class search over a streamed class memory.
// Keeps the running minimum per query and reports prediction plus accuracy counters.
module hd_class_similarity_argmax #(
   parameter int Dhv_SIZE       = 4000,
   parameter int CLA_ADDR_WIDTH = 13,
   parameter int DIST_W         = $clog2(Dhv_SIZE + 1),
   parameter int CNT_W          = 16
) (
   input  logic                      clk,
   input  logic                      reset_in,
   input  logic                      query_valid,
   input  logic [Dhv_SIZE-1:0]       query_hv,
   input  logic [4:0]                true_label,
   input  logic [4:0]                class_num,
   input  logic                      class_valid,
   input  logic [Dhv_SIZE-1:0]       class_hv,
   input  logic [CLA_ADDR_WIDTH-1:0] class_addr,
   output logic                      busy,
   output logic                      pred_valid,
   output logic [4:0]                pred_label,
   output logic [DIST_W-1:0]         pred_dist,
   output logic                      pred_correct,
   output logic [CNT_W-1:0]          query_count,
   output logic [CNT_W-1:0]          correct_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_RESULT = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]          state;
   logic [Dhv_SIZE-1:0] q_hv;
   logic [4:0]          t_label;
   logic [4:0]          c_num;
   logic [4:0]          beat_idx;
   logic                drain_cnt;
   logic                s1_valid;
   logic [DIST_W-1:0]   s1_dist;
   logic [4:0]          s1_idx;
   logic [DIST_W-1:0]   best_dist;
   logic [4:0]          best_idx;
   logic                beat_accept;
   logic                last_beat;

   // The address only tags beats for debug visibility; it never feeds the datapath.
   logic unused_addr;
   assign unused_addr = ^class_addr;

   function automatic logic [DIST_W-1:0] popcount(input logic [Dhv_SIZE-1:0] v);
      logic [DIST_W-1:0] c;
      c = '0;
      for (int i = 0; i < Dhv_SIZE; i++) begin
         c = c + DIST_W'(v[i]);
      end
      return c;
   endfunction

   assign beat_accept = (state == S_SCAN) && class_valid;
   assign last_beat   = beat_accept && (beat_idx == c_num - 5'd1);
   assign busy        = (state != S_IDLE);

   // Stage 1 registers the distance of each accepted beat; stage 2 folds it into the
   // running minimum with strict less-than so ties keep the earlier class.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         state         <= S_IDLE;
         q_hv          <= '0;
         t_label       <= '0;
         c_num         <= '0;
         beat_idx      <= '0;
         drain_cnt     <= 1'b0;
         s1_valid      <= 1'b0;
         s1_dist       <= '0;
         s1_idx        <= '0;
         best_dist     <= '0;
         best_idx      <= '0;
         pred_valid    <= 1'b0;
         pred_label    <= '0;
         pred_dist     <= '0;
         pred_correct  <= 1'b0;
         query_count   <= '0;
         correct_count <= '0;
      end else begin
         pred_valid <= 1'b0;
         s1_valid   <= beat_accept;
         if (beat_accept) begin
            s1_dist  <= popcount(q_hv ^ class_hv);
            s1_idx   <= beat_idx;
            beat_idx <= beat_idx + 5'd1;
         end
         if (s1_valid && (s1_dist < best_dist)) begin
            best_dist <= s1_dist;
            best_idx  <= s1_idx;
         end
         case (state)
            S_IDLE: begin
               if (query_valid && (class_num != 5'd0)) begin
                  q_hv      <= query_hv;
                  t_label   <= true_label;
                  c_num     <= class_num;
                  beat_idx  <= '0;
                  best_dist <= '1;
                  best_idx  <= '0;
                  state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (last_beat) begin
                  drain_cnt <= 1'b0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_cnt) begin
                  state <= S_RESULT;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            default: begin
               pred_valid   <= 1'b1;
               pred_label   <= best_idx;
               pred_dist    <= best_dist;
               pred_correct <= (best_idx == t_label);
               if (query_count != CNT_MAX) begin
                  query_count <= query_count + CNT_W'(1);
               end
               if ((best_idx == t_label) && (correct_count != CNT_MAX)) begin
                  correct_count <= correct_count + CNT_W'(1);
               end
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hd_class_similarity_argmax.sv
// Randomized and directed bench for hd_class_similarity_argmax with an argmin reference model.
// Small hypervectors and a 2-bit counter width keep ties and saturation frequent.
module tb_hd_class_similarity_argmax;

   localparam int DHV     = 8;
   localparam int AW      = 4;
   localparam int DW      = 4;
   localparam int CW      = 2;
   localparam int CNT_MAX = 3;

   logic           clk;
   logic           reset_in;
   logic           query_valid;
   logic [DHV-1:0] query_hv;
   logic [4:0]     true_label;
   logic [4:0]     class_num;
   logic           class_valid;
   logic [DHV-1:0] class_hv;
   logic [AW-1:0]  class_addr;
   logic           busy;
   logic           pred_valid;
   logic [4:0]     pred_label;
   logic [DW-1:0]  pred_dist;
   logic           pred_correct;
   logic [CW-1:0]  query_count;
   logic [CW-1:0]  correct_count;

   hd_class_similarity_argmax #(
      .Dhv_SIZE(DHV), .CLA_ADDR_WIDTH(AW), .DIST_W(DW), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_in(reset_in), .query_valid(query_valid), .query_hv(query_hv),
      .true_label(true_label), .class_num(class_num), .class_valid(class_valid),
      .class_hv(class_hv), .class_addr(class_addr), .busy(busy), .pred_valid(pred_valid),
      .pred_label(pred_label), .pred_dist(pred_dist), .pred_correct(pred_correct),
      .query_count(query_count), .correct_count(correct_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   int       expPulseCyc = -1;
   int       expLabel = 0, expDist = 0, expCorrect = 0;
   int       heldLabel = 0, heldDist = 0, heldCorrect = 0;
   int       expQ = 0, expC = 0;
   int       busyFrom = 0, busyTo = 0;
   bit       inReset = 1'b1;

   logic [DHV-1:0] cls [32];
   int             gapsBefore [32];
   bit             injectQuery = 1'b0;
   bit             extraBeats = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Compare process: checks every output on every cycle outside reset.
   always @(negedge clk) begin
      bit pulse;
      if (!inReset) begin
         pulse = (cyc == expPulseCyc);
         checkOutput("pred_valid", pred_valid, pulse);
         if (pulse) begin
            heldLabel   = expLabel;
            heldDist    = expDist;
            heldCorrect = expCorrect;
            if (expQ < CNT_MAX) expQ++;
            if (expCorrect != 0 && expC < CNT_MAX) expC++;
         end
         checkOutput("pred_label", pred_label, heldLabel);
         checkOutput("pred_dist", pred_dist, heldDist);
         checkOutput("pred_correct", pred_correct, heldCorrect);
         checkOutput("query_count", query_count, expQ);
         checkOutput("correct_count", correct_count, expC);
         checkOutput("busy", busy, (cyc >= busyFrom && cyc < busyTo));
      end
   end

   task automatic doReset();
      inReset     = 1'b1;
      reset_in    = 1'b1;
      query_valid = 1'b0;
      class_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_in    = 1'b0;
      expPulseCyc = -1;
      heldLabel   = 0;
      heldDist    = 0;
      heldCorrect = 0;
      expQ        = 0;
      expC        = 0;
      busyFrom    = 0;
      busyTo      = 0;
      inReset     = 1'b0;
   endtask

   task automatic clearGaps();
      for (int i = 0; i < 32; i++) gapsBefore[i] = 0;
      injectQuery = 1'b0;
      extraBeats  = 1'b0;
   endtask

   // Drives one query and its class beats; abortAfter >= 0 resets the DUT before that beat.
   task automatic applyStimulus(input logic [DHV-1:0] q, input logic [4:0] tl, input int n, input int abortAfter);
      int lastDrive;
      int bestD;
      int bestI;
      int d;
      lastDrive   = cyc;
      class_valid = 1'b0;
      query_valid = 1'b1;
      query_hv    = q;
      true_label  = tl;
      class_num   = 5'(n);
      busyFrom    = cyc + 1;
      busyTo      = 1 << 30;
      @(posedge clk); #1;
      query_valid = 1'b0;
      query_hv    = DHV'($urandom);
      true_label  = 5'($urandom);
      class_num   = 5'($urandom);
      for (int i = 0; i < n; i++) begin
         if (i == abortAfter) begin
            doReset();
            return;
         end
         for (int g = 0; g < gapsBefore[i]; g++) begin
            class_valid = 1'b0;
            class_hv    = DHV'($urandom);
            class_addr  = AW'($urandom);
            if (injectQuery) begin
               query_valid = 1'b1;
               class_num   = 5'd1;
               true_label  = 5'($urandom);
               query_hv    = DHV'($urandom);
            end
            @(posedge clk); #1;
            query_valid = 1'b0;
         end
         class_valid = 1'b1;
         class_hv    = cls[i];
         class_addr  = AW'(i);
         lastDrive   = cyc;
         @(posedge clk); #1;
      end
      class_valid = 1'b0;
      bestD = DHV + 1;
      bestI = 0;
      for (int i = 0; i < n; i++) begin
         d = $countones(q ^ cls[i]);
         if (d < bestD) begin
            bestD = d;
            bestI = i;
         end
      end
      expLabel    = bestI;
      expDist     = bestD;
      expCorrect  = (bestI == int'(tl)) ? 1 : 0;
      expPulseCyc = lastDrive + 4;
      busyTo      = expPulseCyc;
      if (extraBeats) begin
         repeat (3) begin
            class_valid = 1'b1;
            class_hv    = DHV'($urandom);
            @(posedge clk); #1;
         end
      end
      class_valid = 1'b0;
      while (cyc < expPulseCyc) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic ignoredQuery();
      query_valid = 1'b1;
      class_num   = 5'd0;
      query_hv    = DHV'($urandom);
      class_valid = 1'b1;
      class_hv    = DHV'($urandom);
      @(posedge clk); #1;
      query_valid = 1'b0;
      repeat (3) begin
         class_valid = 1'b1;
         class_hv    = DHV'($urandom);
         @(posedge clk); #1;
      end
      class_valid = 1'b0;
   endtask

   task automatic loadExample();
      clearGaps();
      cls[0] = 8'hF1;
      cls[1] = 8'h0F;
      cls[2] = 8'hF0;
   endtask

   initial begin
      int n;
      logic [DHV-1:0] q;
      logic [4:0] tl;
      reset_in    = 1'b0;
      query_valid = 1'b0;
      query_hv    = '0;
      true_label  = '0;
      class_num   = '0;
      class_valid = 1'b0;
      class_hv    = '0;
      class_addr  = '0;
      @(posedge clk); #1;
      doReset();
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_pred_valid", pred_valid, 0);
      checkOutput("reset_pred_label", pred_label, 0);
      checkOutput("reset_query_count", query_count, 0);

      loadExample();
      applyStimulus(8'hF0, 5'd2, 3, -1);
      checkOutput("ex_model_label", expLabel, 2);
      checkOutput("ex_pred_valid", pred_valid, 1);
      checkOutput("ex_pred_label", pred_label, 2);
      checkOutput("ex_pred_dist", pred_dist, 0);
      checkOutput("ex_pred_correct", pred_correct, 1);
      checkOutput("ex_query_count", query_count, 1);
      checkOutput("ex_correct_count", correct_count, 1);

      clearGaps();
      cls[0] = 8'h01;
      cls[1] = 8'h02;
      cls[2] = 8'hFF;
      applyStimulus(8'h00, 5'd1, 3, -1);
      checkOutput("tie_model_dist", expDist, 1);
      checkOutput("tie_pred_label", pred_label, 0);
      checkOutput("tie_pred_dist", pred_dist, 1);
      checkOutput("tie_pred_correct", pred_correct, 0);
      checkOutput("tie_correct_count", correct_count, 1);
      checkOutput("tie_query_count", query_count, 2);

      loadExample();
      gapsBefore[1] = 2;
      gapsBefore[2] = 1;
      injectQuery   = 1'b1;
      extraBeats    = 1'b1;
      applyStimulus(8'hF0, 5'd2, 3, -1);
      checkOutput("gap_pred_label", pred_label, 2);
      checkOutput("gap_pred_dist", pred_dist, 0);
      checkOutput("gap_pred_correct", pred_correct, 1);
      checkOutput("gap_correct_count", correct_count, 2);

      clearGaps();
      for (int i = 0; i < 5; i++) cls[i] = DHV'($urandom);
      applyStimulus(8'h3C, 5'd0, 5, 2);
      checkOutput("abort_query_count", query_count, 0);
      checkOutput("abort_correct_count", correct_count, 0);
      repeat (6) @(posedge clk);
      #1;
      loadExample();
      applyStimulus(8'hF0, 5'd2, 3, -1);
      checkOutput("post_abort_query_count", query_count, 1);

      ignoredQuery();
      checkOutput("ignored_busy", busy, 0);

      doReset();
      for (int k = 0; k < 5; k++) begin
         loadExample();
         applyStimulus(8'hF0, 5'd2, 3, -1);
      end
      checkOutput("sat_query_count", query_count, 3);
      checkOutput("sat_correct_count", correct_count, 3);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("sat_hold_query_count", query_count, 3);

      for (int k = 0; k < 40; k++) begin
         clearGaps();
         n  = (k % 10 == 9) ? 31 : int'($urandom_range(1, 8));
         q  = DHV'($urandom);
         tl = 5'($urandom_range(0, n - 1));
         for (int i = 0; i < n; i++) begin
            cls[i]        = DHV'($urandom);
            gapsBefore[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         end
         if ($urandom_range(0, 1) == 1) cls[$urandom_range(0, n - 1)] = q;
         injectQuery = 1'($urandom_range(0, 1));
         extraBeats  = 1'($urandom_range(0, 1));
         if (k % 7 == 3) ignoredQuery();
         if (k % 13 == 5) doReset();
         applyStimulus(q, tl, n, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
